// File: rtl/unidade_de_busca_pkg.sv
// Shared definitions for the instruction fetch unit.
package pacote_busca;

   localparam int unsigned LARGURA = 32;

   // Fetch FSM encoding.
   typedef enum logic {
      BUSCA = 1'b0,
      FIM   = 1'b1
   } estado_t;

   // PC step between consecutive instruction words.
   localparam logic [LARGURA-1:0] PASSO_PC = 32'd4;

   // Clears the byte offset of a redirect target.
   localparam logic [LARGURA-1:0] MASCARA_ALINHAMENTO = 32'hFFFF_FFFC;

endpackage

// File: rtl/unidade_de_busca_registrador_pc.sv
// Program counter register: reset value, word-aligned load on redirect, step on fetch.
module registrador_pc
   import pacote_busca::*;
#(
   parameter logic [LARGURA-1:0] VALOR_RESET = 32'd0
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic               carregar,
   input  logic [LARGURA-1:0] alvo,
   input  logic               incrementar,
   output logic [LARGURA-1:0] pc
);

   // Reset beats redirect, redirect beats sequential increment.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc <= VALOR_RESET;
      end else if (carregar) begin
         pc <= alvo & MASCARA_ALINHAMENTO;
      end else if (incrementar) begin
         pc <= pc + PASSO_PC;
      end
   end

endmodule

// File: rtl/unidade_de_busca.sv
// Instruction fetch unit: PC, registered instruction slot with valid/ready, redirect and end-of-program stop.
module unidade_de_busca
   import pacote_busca::*;
#(
   parameter logic [LARGURA-1:0] PC_INICIAL = 32'd0,
   parameter logic [LARGURA-1:0] LIMITE     = 32'd31
) (
   input  logic               clock,
   input  logic               reset_n,
   output logic [LARGURA-1:0] endereco,
   input  logic [LARGURA-1:0] instrucao,
   input  logic               desvio,
   input  logic [LARGURA-1:0] alvo,
   input  logic               pronto,
   output logic               valido,
   output logic [LARGURA-1:0] instrucao_saida,
   output logic [LARGURA-1:0] pc_saida,
   output logic [LARGURA-1:0] pc_mais4,
   output logic               fim,
   output logic [LARGURA-1:0] contagem
);

   estado_t            estado;
   estado_t            estado_prox;
   logic [LARGURA-1:0] pc;
   logic               slot_livre_c;
   logic               dispara_c;
   logic               aceita_c;

   registrador_pc #(
      .VALOR_RESET (PC_INICIAL)
   ) u_registrador_pc (
      .clock       (clock),
      .reset_n     (reset_n),
      .carregar    (desvio),
      .alvo        (alvo),
      .incrementar (dispara_c),
      .pc          (pc)
   );

   assign slot_livre_c = !valido || pronto;
   assign dispara_c    = (estado == BUSCA) && slot_livre_c && (pc <= LIMITE) && !desvio;
   assign aceita_c     = valido && pronto && !desvio;

   assign endereco = pc;
   assign pc_mais4 = pc_saida + PASSO_PC;
   assign fim      = (estado == FIM);

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         estado <= BUSCA;
      end else begin
         estado <= estado_prox;
      end
   end

   // Next state: redirect always restarts fetching; running past LIMITE with a free slot stops it.
   always_comb begin
      estado_prox = estado;
      if (desvio) begin
         estado_prox = BUSCA;
      end else if ((estado == BUSCA) && slot_livre_c && (pc > LIMITE)) begin
         estado_prox = FIM;
      end
   end

   // Output slot: capture on fire, drop on redirect, empty once consumed with nothing new.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         valido          <= 1'b0;
         instrucao_saida <= '0;
         pc_saida        <= '0;
      end else if (desvio) begin
         valido <= 1'b0;
      end else if (dispara_c) begin
         valido          <= 1'b1;
         instrucao_saida <= instrucao;
         pc_saida        <= pc;
      end else if (slot_livre_c) begin
         valido <= 1'b0;
      end
   end

   // Count of instructions handed to decode; dropped words do not count.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         contagem <= '0;
      end else if (aceita_c) begin
         contagem <= contagem + 32'd1;
      end
   end

endmodule

// File: tb/tb_unidade_de_busca.sv
// Bench for unidade_de_busca: directed scenarios plus random traffic against a rule-level model.
module tb_unidade_de_busca;

   logic        clock;
   logic        reset_n;
   logic [31:0] endereco;
   logic [31:0] instrucao;
   logic        desvio;
   logic [31:0] alvo;
   logic        pronto;
   logic        valido;
   logic [31:0] instrucao_saida;
   logic [31:0] pc_saida;
   logic [31:0] pc_mais4;
   logic        fim;
   logic [31:0] contagem;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:7];

   // Reference model state (what the fetch unit should hold after each edge).
   logic [31:0] m_pc;
   logic        m_valido;
   logic [31:0] m_inst;
   logic [31:0] m_pcs;
   logic [31:0] m_cont;
   logic        m_fim;

   unidade_de_busca dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .endereco        (endereco),
      .instrucao       (instrucao),
      .desvio          (desvio),
      .alvo            (alvo),
      .pronto          (pronto),
      .valido          (valido),
      .instrucao_saida (instrucao_saida),
      .pc_saida        (pc_saida),
      .pc_mais4        (pc_mais4),
      .fim             (fim),
      .contagem        (contagem)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Instruction memory: 8 populated words at 0..28, garbage beyond.
   assign instrucao = (endereco <= 32'd31) ? mem[endereco[4:2]] : 32'hDEAD_BEEF;

   function automatic logic [31:0] palavra(input logic [31:0] a);
      logic [2:0] idx;
      idx = a[4:2];
      return (a <= 32'd31) ? mem[idx] : 32'hDEAD_BEEF;
   endfunction

   // One clock edge of the fetch rules, applied to the model.
   task automatic modelo(input logic rn, input logic d, input logic [31:0] a, input logic p);
      logic livre;
      if (!rn) begin
         m_pc = 32'd0; m_valido = 1'b0; m_inst = 32'd0; m_pcs = 32'd0; m_cont = 32'd0; m_fim = 1'b0;
      end else if (d) begin
         m_pc = {a[31:2], 2'b00};
         m_valido = 1'b0;
         m_fim = 1'b0;
      end else begin
         livre = !m_valido || p;
         if (m_valido && p) m_cont = m_cont + 32'd1;
         if (!m_fim && livre && m_pc <= 32'd31) begin
            m_inst = palavra(m_pc);
            m_pcs = m_pc;
            m_valido = 1'b1;
            m_pc = m_pc + 32'd4;
         end else if (livre) begin
            m_valido = 1'b0;
            if (!m_fim) m_fim = 1'b1;
         end
      end
   endtask

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic conferir();
      cmp("endereco", endereco, m_pc);
      cmp("valido", 32'(valido), 32'(m_valido));
      cmp("instrucao_saida", instrucao_saida, m_inst);
      cmp("pc_saida", pc_saida, m_pcs);
      cmp("pc_mais4", pc_mais4, m_pcs + 32'd4);
      cmp("fim", 32'(fim), 32'(m_fim));
      cmp("contagem", contagem, m_cont);
   endtask

   task automatic passo(input logic rn, input logic d, input logic [31:0] a, input logic p);
      @(negedge clock);
      reset_n = rn; desvio = d; alvo = a; pronto = p;
      modelo(rn, d, a, p);
      @(posedge clock);
      #1;
      conferir();
   endtask

   initial begin
      logic [31:0] instr_antes;
      for (int i = 0; i < 8; i++) mem[i] = $urandom;
      reset_n = 1'b0; desvio = 1'b0; alvo = 32'd0; pronto = 1'b0;
      m_pc = 32'd0; m_valido = 1'b0; m_inst = 32'd0; m_pcs = 32'd0; m_cont = 32'd0; m_fim = 1'b0;

      // Reset
      passo(1'b0, 1'b0, 32'd0, 1'b0);
      passo(1'b0, 1'b0, 32'd0, 1'b1);
      cmp("rst_valido", 32'(valido), 32'd0);
      cmp("rst_pc_mais4", pc_mais4, 32'd4);
      cmp("rst_fim", 32'(fim), 32'd0);

      // Free run to the end of memory
      passo(1'b1, 1'b0, 32'd0, 1'b1);
      cmp("first_pc_saida", pc_saida, 32'd0);
      cmp("first_valido", 32'(valido), 32'd1);
      for (int i = 0; i < 9; i++) passo(1'b1, 1'b0, 32'd0, 1'b1);
      cmp("run_fim", 32'(fim), 32'd1);
      cmp("run_valido", 32'(valido), 32'd0);
      cmp("run_contagem", contagem, 32'd8);

      // Redirect out of FIM
      passo(1'b1, 1'b1, 32'd0, 1'b1);
      cmp("leave_fim", 32'(fim), 32'd0);
      passo(1'b1, 1'b0, 32'd0, 1'b1);
      cmp("leave_pc_saida", pc_saida, 32'd0);
      passo(1'b1, 1'b0, 32'd0, 1'b1);

      // Redirect while pc_saida = 4 and pronto = 1: word dropped, not counted
      passo(1'b1, 1'b1, 32'h10, 1'b1);
      cmp("redir_valido", 32'(valido), 32'd0);
      cmp("redir_endereco", endereco, 32'h10);
      cmp("redir_contagem", contagem, 32'd9);
      passo(1'b1, 1'b0, 32'd0, 1'b1);
      cmp("redir_pc_saida", pc_saida, 32'h10);

      // Stall at pc_saida = 8
      passo(1'b1, 1'b1, 32'd0, 1'b1);
      for (int i = 0; i < 3; i++) passo(1'b1, 1'b0, 32'd0, 1'b1);
      instr_antes = instrucao_saida;
      for (int i = 0; i < 3; i++) passo(1'b1, 1'b0, 32'd0, 1'b0);
      cmp("stall_pc_saida", pc_saida, 32'd8);
      cmp("stall_endereco", endereco, 32'd12);
      cmp("stall_instr", instrucao_saida, instr_antes);
      passo(1'b1, 1'b0, 32'd0, 1'b1);
      cmp("stall_release", pc_saida, 32'd12);

      // Misaligned target
      passo(1'b1, 1'b1, 32'h0E, 1'b1);
      cmp("misaligned", endereco, 32'h0C);

      // Reset mid-stream with pc = 20, valido = 1, pronto = 0, desvio = 1
      for (int i = 0; i < 10 && m_pc != 32'd20; i++) passo(1'b1, 1'b0, 32'd0, 1'b1);
      cmp("mid_pc", endereco, 32'd20);
      passo(1'b1, 1'b0, 32'd0, 1'b0);
      passo(1'b0, 1'b1, 32'h8, 1'b0);
      cmp("mid_valido", 32'(valido), 32'd0);
      cmp("mid_endereco", endereco, 32'd0);
      cmp("mid_contagem", contagem, 32'd0);
      cmp("mid_instr", instrucao_saida, 32'd0);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         passo(($urandom_range(0, 49) != 0), ($urandom_range(0, 9) == 0),
               32'($urandom_range(0, 40)), ($urandom_range(0, 3) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
